// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment MMIO controller: register offsets,
// CTRL bit positions, digit geometry and the byte-strobe merge helper.
package seven_seg_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGIT_N = 6;
    localparam int SEG_W   = DIGIT_W * DIGIT_N;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_BLINK_BIT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    // Only the three low bytes hold digits; byte 3 of a DATA write is dropped.
    function automatic logic [SEG_W-1:0] merge_digits(input logic [SEG_W-1:0] cur,
                                                      input logic [SEG_W-1:0] wr,
                                                      input logic [2:0]       strb);
        logic [SEG_W-1:0] res;
        res = cur;
        for (int b = 0; b < 3; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wr[8*b +: 8];
            end else begin
                res[8*b +: 8] = cur[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seven_seg_mmio_ctrl_if.sv
// picorv32 native memory bus bundle between the CPU and the display controller.
interface seven_seg_mmio_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/seven_seg_blink_timer.sv
// Blink cadence: 1 ms prescaler, half-period ms counter and phase flop.
// Everything is held cleared while run is low.
module seven_seg_blink_timer #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BLINK_HALF_MS = 500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic phase
);
    localparam int PRE_MAX = CLK_HZ / 1000 - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam int MS_MAX  = BLINK_HALF_MS - 1;
    localparam int MS_W    = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_MAX);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_MAX);

    logic [PRE_W-1:0] pre_r;
    logic [MS_W-1:0]  ms_r;
    logic             phase_r;
    logic             tick_s;
    logic             wrap_s;

    // 1 ms tick and half-period wrap detection
    always_comb begin
        tick_s = (pre_r == PRE_LAST);
        wrap_s = tick_s && (ms_r == MS_LAST);
    end

    // Counter and phase state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_r   <= {PRE_W{1'b0}};
            ms_r    <= {MS_W{1'b0}};
            phase_r <= 1'b0;
        end else if (!run) begin
            pre_r   <= {PRE_W{1'b0}};
            ms_r    <= {MS_W{1'b0}};
            phase_r <= 1'b0;
        end else begin
            if (tick_s) begin
                pre_r <= {PRE_W{1'b0}};
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
            if (wrap_s) begin
                ms_r    <= {MS_W{1'b0}};
                phase_r <= ~phase_r;
            end else if (tick_s) begin
                ms_r    <= ms_r + MS_W'(1);
            end else begin
                ms_r    <= ms_r;
            end
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/seven_seg_mmio_ctrl.sv
// Memory-mapped register front end for the six-digit seven-segment display.
// Define SEVEN_SEG_BLINK_EN to build in the blink timer and a writable CTRL.BLINK.
module seven_seg_mmio_ctrl
    import seven_seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
    parameter int          CLK_HZ        = 50_000_000,
    parameter int          BLINK_HALF_MS = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seven_seg_mmio_ctrl_if.slave  bus,
    output logic                  seg_en,
    output logic [SEG_W-1:0]      seg_vals
);
    bus_state_t       state_r, state_nxt_s;
    logic             hit_s, ack_s, wr_ctrl_s;
    logic [3:0]       off_s;
    logic [SEG_W-1:0] data_r, data_nxt_s;
    logic             enable_r, enable_nxt_s;
    logic             blink_r, phase_s;
    logic [31:0]      rdata_mux_s;
    logic             mem_ready_r;
    logic [31:0]      mem_rdata_r;
    logic             seg_en_r;
    logic [SEG_W-1:0] seg_vals_r;
    logic             unused_s;

    assign unused_s = &{1'b0, bus.mem_wdata[31:24], bus.mem_wstrb[3], bus.mem_addr[1:0]};

    // Address decode
    always_comb begin
        hit_s = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
        off_s = {bus.mem_addr[3:2], 2'b00};
    end

    // Handshake FSM: the ACK state blocks a re-acknowledge while valid is still held
    always_comb begin
        state_nxt_s = state_r;
        ack_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    ack_s       = 1'b1;
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Register next values from the acknowledged write
    always_comb begin
        data_nxt_s   = data_r;
        enable_nxt_s = enable_r;
        wr_ctrl_s    = 1'b0;
        if (ack_s && (off_s == OFF_DATA)) begin
            data_nxt_s = merge_digits(data_r, bus.mem_wdata[SEG_W-1:0], bus.mem_wstrb[2:0]);
        end else begin
            data_nxt_s = data_r;
        end
        if (ack_s && (off_s == OFF_CTRL) && bus.mem_wstrb[0]) begin
            enable_nxt_s = bus.mem_wdata[CTRL_ENABLE_BIT];
            wr_ctrl_s    = 1'b1;
        end else begin
            enable_nxt_s = enable_r;
            wr_ctrl_s    = 1'b0;
        end
    end

    // Read data mux, sampled on the acknowledge edge
    always_comb begin
        rdata_mux_s = 32'h0;
        case (off_s)
            OFF_DATA:   rdata_mux_s = {8'h00, data_r};
            OFF_CTRL:   rdata_mux_s = {30'h0, blink_r, enable_r};
            OFF_STATUS: rdata_mux_s = {30'h0, seg_en_r, phase_s};
            default:    rdata_mux_s = 32'h0;
        endcase
    end

`ifdef SEVEN_SEG_BLINK_EN
    logic blink_nxt_s;

    // BLINK next value: a CTRL write always wins over the running cadence
    always_comb begin
        blink_nxt_s = blink_r;
        if (wr_ctrl_s) begin
            blink_nxt_s = bus.mem_wdata[CTRL_BLINK_BIT];
        end else begin
            blink_nxt_s = blink_r;
        end
    end

    // BLINK register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_r <= 1'b0;
        end else begin
            blink_r <= blink_nxt_s;
        end
    end

    // Clearing on the write edge of 1->0 unblanks at once; 0->1 starts from a cleared timer
    seven_seg_blink_timer #(
        .CLK_HZ        (CLK_HZ),
        .BLINK_HALF_MS (BLINK_HALF_MS)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (blink_r & blink_nxt_s),
        .phase   (phase_s)
    );
`else
    logic unused_blink_s;
    assign unused_blink_s = wr_ctrl_s;
    assign blink_r        = 1'b0;
    assign phase_s        = 1'b0;
`endif

    // Bus response, register file and display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0;
            data_r      <= {SEG_W{1'b0}};
            enable_r    <= 1'b0;
            seg_en_r    <= 1'b0;
            seg_vals_r  <= {SEG_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            mem_ready_r <= ack_s;
            mem_rdata_r <= ack_s ? rdata_mux_s : 32'h0;
            data_r      <= data_nxt_s;
            enable_r    <= enable_nxt_s;
            seg_en_r    <= enable_r & ~(blink_r & phase_s);
            seg_vals_r  <= data_r;
        end
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign seg_en        = seg_en_r;
    assign seg_vals      = seg_vals_r;

endmodule

// File: tb/tb_seven_seg_mmio_ctrl.sv
// Self-checking bench for seven_seg_mmio_ctrl; expectations adapt to SEVEN_SEG_BLINK_EN.
module tb_seven_seg_mmio_ctrl;

    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam int          TB_HZ   = 5000;
    localparam int          TB_HALF = 3;
    localparam int          PH      = (TB_HZ / 1000) * TB_HALF;

    logic        clk;
    logic        reset_n;
    logic        seg_en;
    logic [23:0] seg_vals;
    int          n_checks;
    int          n_errors;
    logic [23:0] m_data;

    seven_seg_mmio_ctrl_if bus ();

    seven_seg_mmio_ctrl #(
        .BASE_ADDR     (BASE),
        .CLK_HZ        (TB_HZ),
        .BLINK_HALF_MS (TB_HALF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .seg_en   (seg_en),
        .seg_vals (seg_vals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected display enable k cycles after the first visible cycle of a blink run
    function automatic logic blink_exp(input int k);
`ifdef SEVEN_SEG_BLINK_EN
        return ((k / PH) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    // Drives one bus request and holds valid one extra cycle after ready
    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output int lat, output logic reack,
                            output logic se_rdy, output logic [23:0] sv_rdy);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        lat = 0; rd = 32'h0; reack = 1'b0; se_rdy = 1'b0; sv_rdy = 24'h0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) begin
                lat = i; rd = bus.mem_rdata; se_rdy = seg_en; sv_rdy = seg_vals;
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            reack = bus.mem_ready;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.mem_ready, bus.mem_rdata, seg_en, seg_vals} !== 58'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b rdata=%h seg_en=%b seg_vals=%h, need all 0",
                     bus.mem_ready, bus.mem_rdata, seg_en, seg_vals);
        end
        @(negedge clk); reset_n = 1'b1;
        m_data = 24'h0;
        for (int o = 0; o < 16; o += 4) begin
            bus_xfer(BASE + 32'(o), 32'h0, 4'h0, rd, lat, rk, se, sv);
            n_checks++;
            if (lat !== 1 || rk !== 1'b0 || rd !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_read off=%0h: lat=%0d reack=%b rdata=%h, need lat=1 reack=0 rdata=0",
                         o, lat, rk, rd);
            end
        end
    endtask

    task automatic test_data_write();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        bus_xfer(BASE, 32'h00AB_CDEF, 4'hF, rd, lat, rk, se, sv);
        n_checks++;
        if (lat !== 1 || sv !== 24'h0 || seg_vals !== 24'hABCDEF) begin
            n_errors++;
            $display("FAIL data_full: lat=%0d at_ready=%h after=%h, need lat=1 at_ready=000000 after=abcdef",
                     lat, sv, seg_vals);
        end
        m_data = 24'hABCDEF;
        bus_xfer(BASE, 32'h0000_0012, 4'h1, rd, lat, rk, se, sv);
        n_checks++;
        if (seg_vals !== 24'hABCD12) begin
            n_errors++;
            $display("FAIL data_strobe: seg_vals=%h, need abcd12", seg_vals);
        end
        m_data = 24'hABCD12;
    endtask

    task automatic test_random_data();
        logic [31:0] rd, d, a; int lat; logic rk, se; logic [23:0] sv;
        logic [3:0] s;
        int pick;
        for (int n = 0; n < 24; n++) begin
            d    = $urandom;
            s    = 4'($urandom_range(1, 15));
            pick = $urandom_range(0, 3);
            a    = (pick == 2) ? BASE + 32'h8 : (pick == 3) ? BASE + 32'hC : BASE;
            if (a == BASE) begin
                for (int b = 0; b < 3; b++)
                    if (s[b]) m_data[8*b +: 8] = d[8*b +: 8];
            end
            bus_xfer(a, d, s, rd, lat, rk, se, sv);
            n_checks++;
            if (lat !== 1 || rk !== 1'b0 || seg_vals !== m_data) begin
                n_errors++;
                $display("FAIL rand_write #%0d addr=%h strb=%b: lat=%0d reack=%b seg_vals=%h, need 1/0/%h",
                         n, a, s, lat, rk, seg_vals, m_data);
            end
            if (n % 4 == 3) begin
                bus_xfer(BASE, 32'h0, 4'h0, rd, lat, rk, se, sv);
                n_checks++;
                if (rd !== {8'h00, m_data}) begin
                    n_errors++;
                    $display("FAIL rand_readback #%0d: rdata=%h, need %h", n, rd, {8'h00, m_data});
                end
            end
        end
    endtask

    task automatic test_ctrl_strobe();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        bus_xfer(BASE + 32'h4, 32'h0000_0003, 4'b1110, rd, lat, rk, se, sv);
        bus_xfer(BASE + 32'h4, 32'h0, 4'h0, rd, lat, rk, se, sv);
        n_checks++;
        if (rd !== 32'h0 || seg_en !== 1'b0) begin
            n_errors++;
            $display("FAIL ctrl_no_byte0: ctrl=%h seg_en=%b, need 0/0", rd, seg_en);
        end
    endtask

    task automatic test_blink();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        logic [31:0] exp_ctrl;
        int k;
        bus_xfer(BASE + 32'h4, 32'h0000_0003, 4'h1, rd, lat, rk, se, sv);
        n_checks++;
        if (se !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_latency: seg_en at ready=%b, need 0", se);
        end
        for (k = 0; k < 4 * PH; k++) begin
            n_checks++;
            if (seg_en !== blink_exp(k)) begin
                n_errors++;
                $display("FAIL blink_cadence k=%0d: seg_en=%b, need %b", k, seg_en, blink_exp(k));
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < PH + 2; i++) begin
            @(posedge clk); #1;
        end
        k = 5 * PH + 2;
        n_checks++;
        if (seg_en !== blink_exp(k)) begin
            n_errors++;
            $display("FAIL blink_midblank: seg_en=%b, need %b", seg_en, blink_exp(k));
        end
        bus_xfer(BASE + 32'h4, 32'h0000_0001, 4'h1, rd, lat, rk, se, sv);
        n_checks++;
        if (se !== blink_exp(k + 1) || seg_en !== 1'b1) begin
            n_errors++;
            $display("FAIL blink_off_unblank: at_ready=%b after=%b, need %b/1", se, seg_en, blink_exp(k + 1));
        end
        bus_xfer(BASE + 32'h8, 32'h0, 4'h0, rd, lat, rk, se, sv);
        n_checks++;
        if (rd !== 32'h2) begin
            n_errors++;
            $display("FAIL status_visible: status=%h, need 00000002", rd);
        end
        bus_xfer(BASE + 32'h4, 32'h0000_0002, 4'h1, rd, lat, rk, se, sv);
        bus_xfer(BASE + 32'h4, 32'h0, 4'h0, rd, lat, rk, se, sv);
`ifdef SEVEN_SEG_BLINK_EN
        exp_ctrl = 32'h2;
`else
        exp_ctrl = 32'h0;
`endif
        n_checks++;
        if (rd !== exp_ctrl || seg_en !== 1'b0) begin
            n_errors++;
            $display("FAIL ctrl_disabled: ctrl=%h seg_en=%b, need %h/0", rd, seg_en, exp_ctrl);
        end
        bus_xfer(BASE, 32'h0055_6677, 4'h7, rd, lat, rk, se, sv);
        m_data = 24'h556677;
        n_checks++;
        if (seg_vals !== m_data || seg_en !== 1'b0) begin
            n_errors++;
            $display("FAIL data_while_blank: seg_vals=%h seg_en=%b, need %h/0", seg_vals, seg_en, m_data);
        end
        bus_xfer(BASE + 32'h8, 32'h0, 4'h0, rd, lat, rk, se, sv);
        n_checks++;
        if ((rd & 32'hFFFF_FFFE) !== 32'h0) begin
            n_errors++;
            $display("FAIL status_disabled: status=%h, need bit1 and upper bits 0", rd);
        end
        bus_xfer(BASE + 32'h4, 32'h0, 4'h1, rd, lat, rk, se, sv);
    endtask

    task automatic test_no_hit();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        logic [31:0] addrs [2];
        addrs[0] = BASE + 32'h10;
        addrs[1] = BASE ^ 32'h1000_0000;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus.mem_valid = 1'b1;
            bus.mem_addr  = addrs[j];
            bus.mem_wdata = 32'hFFFF_FFFF;
            bus.mem_wstrb = 4'hF;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
                    n_errors++;
                    $display("FAIL nohit addr=%h cyc=%0d: ready=%b rdata=%h, need 0/0",
                             addrs[j], i, bus.mem_ready, bus.mem_rdata);
                end
            end
            bus.mem_valid = 1'b0;
            bus.mem_wstrb = 4'h0;
        end
        bus_xfer(BASE, 32'h0, 4'h0, rd, lat, rk, se, sv);
        n_checks++;
        if (rd !== {8'h00, m_data} || seg_vals !== m_data) begin
            n_errors++;
            $display("FAIL nohit_data: rdata=%h seg_vals=%h, need %h", rd, seg_vals, m_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic rk, se; logic [23:0] sv;
        logic seen;
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        m_data = 24'h0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE;
        bus.mem_wdata = 32'h0012_3456;
        bus.mem_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_ready: ready seen=%b, need 1", seen);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b0 || seg_vals !== 24'h0) begin
            n_errors++;
            $display("FAIL rstmid_async: ready=%b seg_vals=%h, need 0/0", bus.mem_ready, seg_vals);
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        reset_n = 1'b1;
        bus_xfer(BASE, 32'h0, 4'h0, rd, lat, rk, se, sv);
        n_checks++;
        if (rd !== 32'h0 || seg_vals !== 24'h0) begin
            n_errors++;
            $display("FAIL rstmid_lost: data=%h seg_vals=%h, need 0/0", rd, seg_vals);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        test_reset();
        test_data_write();
        test_random_data();
        test_ctrl_strobe();
        test_blink();
        test_no_hit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
